// File: rtl/tournament_predictor.sv
// tournament_predictor -- Alpha-21264-style tournament branch predictor.
//
// A local predictor (per-PC history -> 3-bit counters) and a global predictor
// (global history -> 2-bit counters) each vote; a choice table indexed by the
// global history picks which vote becomes the registered prediction. The
// resolved outcome trains all tables. After reset an init sequencer walks
// every table entry before the first request is accepted.
//
// Optional feature macro: BP_STATS_EN (prediction / mispredict counters).
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous active-low reset
//   pred_valid, PC  prediction request, sampled when pred_valid & ready
//   ready           high only while idle (able to accept a request)
//   pred_out_valid  one-cycle pulse, PredictedBranch valid
//   PredictedBranch 1 = taken, held until the next prediction
//   resolve_valid,  outcome strobe + resolved direction, honoured only
//   BranchTaken     while waiting for the outcome
//   mispredict      one-cycle pulse when outcome != PredictedBranch
//   pred_count,     16-bit saturating statistics (0 when BP_STATS_EN is off)
//   mispred_count
module tournament_predictor #(
   parameter int PC_W  = 10,
   parameter int LHR_W = 10,
   parameter int GHR_W = 12   // must be >= PC_W and >= LHR_W (init walks GHR space)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pred_valid,
   input  logic [PC_W-1:0]  PC,
   output logic             ready,
   output logic             pred_out_valid,
   output logic             PredictedBranch,
   input  logic             resolve_valid,
   input  logic             BranchTaken,
   output logic             mispredict,
   output logic [15:0]      pred_count,
   output logic [15:0]      mispred_count
);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT} state_t;

   state_t state, state_n;

   // Table storage: contents are established by the init walk, not by reset.
   logic [LHR_W-1:0] lht  [2**PC_W];
   logic [2:0]       lctr [2**LHR_W];
   logic [1:0]       gctr [2**GHR_W];
   logic [1:0]       chc  [2**GHR_W];

   logic [GHR_W:0]   idx;
   logic [GHR_W-1:0] ghr, ghr_q;
   logic [PC_W-1:0]  pc_q;
   logic [LHR_W-1:0] lh_q;
   logic             lp_q, gp_q;

   logic             init_last, accept, resolve;
   logic [LHR_W-1:0] lh_rd;
   logic             lp_rd, gp_rd, ch_rd;
   logic [2:0]       lcur, lnext;
   logic [1:0]       gcur, gnext, ccur, cnext;

   assign init_last = (idx == {1'b0, {GHR_W{1'b1}}});
   assign accept    = (state == S_IDLE) && pred_valid;
   assign resolve   = (state == S_WAIT) && resolve_valid;

   // Lookup path for a new request.
   assign lh_rd = lht[PC];
   assign lp_rd = lctr[lh_rd][2];
   assign gp_rd = gctr[ghr][1];
   assign ch_rd = chc[ghr][1];

   // Training path uses the indices captured at prediction time.
   assign lcur = lctr[lh_q];
   assign gcur = gctr[ghr_q];
   assign ccur = chc[ghr_q];

   always_comb begin
      lnext = lcur;
      gnext = gcur;
      cnext = ccur;
      if (BranchTaken) begin
         if (lcur != 3'd7) lnext = lcur + 3'd1;
         if (gcur != 2'd3) gnext = gcur + 2'd1;
      end else begin
         if (lcur != 3'd0) lnext = lcur - 3'd1;
         if (gcur != 2'd0) gnext = gcur - 2'd1;
      end
      // Choice only learns when the two components disagreed.
      if (lp_q != gp_q) begin
         if (gp_q == BranchTaken) begin
            if (ccur != 2'd3) cnext = ccur + 2'd1;
         end else begin
            if (ccur != 2'd0) cnext = ccur - 2'd1;
         end
      end
   end

   always_comb begin
      state_n = state;
      ready   = 1'b0;
      case (state)
         S_INIT: if (init_last) state_n = S_IDLE;
         S_IDLE: begin
            ready = 1'b1;
            if (pred_valid) state_n = S_WAIT;
         end
         S_WAIT: if (resolve_valid) state_n = S_IDLE;
         default: state_n = S_INIT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (state == S_INIT) begin
         lht [idx[PC_W-1:0]]  <= '0;
         lctr[idx[LHR_W-1:0]] <= 3'b011;
         gctr[idx[GHR_W-1:0]] <= 2'b01;
         chc [idx[GHR_W-1:0]] <= 2'b01;
      end else if (resolve) begin
         lctr[lh_q]  <= lnext;
         gctr[ghr_q] <= gnext;
         chc [ghr_q] <= cnext;
         lht [pc_q]  <= {lh_q[LHR_W-2:0], BranchTaken};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= S_INIT;
         idx             <= '0;
         ghr             <= '0;
         ghr_q           <= '0;
         pc_q            <= '0;
         lh_q            <= '0;
         lp_q            <= 1'b0;
         gp_q            <= 1'b0;
         pred_out_valid  <= 1'b0;
         PredictedBranch <= 1'b0;
         mispredict      <= 1'b0;
      end else begin
         state          <= state_n;
         pred_out_valid <= accept;
         mispredict     <= resolve && (BranchTaken != PredictedBranch);
         if (state == S_INIT) begin
            idx <= idx + 1'b1;
            ghr <= '0;
         end
         if (accept) begin
            pc_q            <= PC;
            lh_q            <= lh_rd;
            lp_q            <= lp_rd;
            gp_q            <= gp_rd;
            ghr_q           <= ghr;
            PredictedBranch <= ch_rd ? gp_rd : lp_rd;
         end
         if (resolve) ghr <= {ghr[GHR_W-2:0], BranchTaken};
      end
   end

`ifdef BP_STATS_EN
   // Cleared only by reset; the init walk leaves them alone.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pred_count    <= '0;
         mispred_count <= '0;
      end else begin
         if (pred_out_valid && pred_count != 16'hFFFF) pred_count <= pred_count + 16'd1;
         if (mispredict && mispred_count != 16'hFFFF) mispred_count <= mispred_count + 16'd1;
      end
   end
`else
   assign pred_count    = '0;
   assign mispred_count = '0;
`endif

endmodule

// File: doc/tournament_predictor.md
# tournament_predictor

Alpha-21264-style tournament branch predictor core: the producer of the per-branch prediction that the predictor assertion/checker block consumes. It accepts a branch PC, returns a registered taken/not-taken prediction chosen between a local-history predictor and a global-history predictor, then accepts the resolved outcome and trains all tables. A post-reset init sequencer clears the table storage before the first request is accepted.

## Interface
- PC_W, 10: branch PC width; local history table has 2^PC_W entries
- LHR_W, 10: local history width; local counter table has 2^LHR_W 3-bit entries
- GHR_W, 12: global history width; global and choice tables have 2^GHR_W 2-bit entries
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pred_valid  in  1  prediction request; PC is sampled when pred_valid & ready
- PC  in  PC_W  branch PC
- ready  out  1  high only in IDLE
- pred_out_valid  out  1  one-cycle pulse; PredictedBranch is valid
- PredictedBranch  out  1  1 = taken; held until the next prediction
- resolve_valid  in  1  outcome strobe, honoured only in WAIT
- BranchTaken  in  1  resolved outcome
- mispredict  out  1  one-cycle pulse when the outcome differs from PredictedBranch
- pred_count  out  16  see Configuration
- mispred_count  out  16  see Configuration

## Operation
- FSM states: INIT, IDLE, WAIT.
- INIT: a (GHR_W+1)-bit counter idx runs 0..2^GHR_W-1, one entry per cycle.
  - Writes LHT[idx mod 2^PC_W]=0, local ctr[idx mod 2^LHR_W]=3'b011, global ctr[idx]=2'b01, choice[idx]=2'b01.
  - At the last idx, goes to IDLE. GHR=0 throughout.
- IDLE: on pred_valid, latches PC into pc_q and goes to WAIT.
  - Reads lh=LHT[PC], lp=local[lh][2], gp=global[GHR][1], ch=choice[GHR][1].
  - Registers PredictedBranch = ch ? gp : lp, and registers lp, gp, lh, GHR alongside it.
- WAIT: pred_valid is ignored. On resolve_valid with outcome t, goes to IDLE and performs the updates below.
  - local[lh] saturating ±1, within 0..7.
  - global[GHR_q] saturating ±1, within 0..3.
  - If lp != gp: choice[GHR_q] +1 if gp==t, else -1, saturating.
  - LHT[pc_q] = {lh[LHR_W-2:0], t}; GHR = {GHR[GHR_W-2:0], t}.
  - mispredict = (t != PredictedBranch).
- resolve_valid outside WAIT is ignored. Outside the WAIT update, no table or history changes.
- Reset values: ready=0, pred_out_valid=0, PredictedBranch=0, mispredict=0, counters=0, GHR=0, state=INIT.
- Reset asserted in any state aborts everything; INIT restarts from idx=0.

## Timing
- INIT lasts exactly 2^GHR_W cycles (4096 by default); ready rises on the following edge.
- Request accepted at edge N: pred_out_valid and PredictedBranch at N+1, ready=0 from N+1.
- Earliest resolve is sampled at edge N+1.
- Resolve at edge M: tables updated at M, mispredict pulses for the cycle after M, ready=1 from M+1.
- The next request, accepted no earlier than M+1, sees the updated tables and histories. There is no bypass path.
- Throughput: at most one branch per 2 cycles.

## Configuration
- BP_STATS_EN defined:
  - pred_count increments on every pred_out_valid.
  - mispred_count increments on every mispredict.
  - Both are 16-bit, saturate at 16'hFFFF, clear on reset, and are not cleared by INIT.
- BP_STATS_EN undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Reset deasserted at cycle 0 -> ready=0 for cycles 0..4095, ready=1 at cycle 4096; PredictedBranch=0 and mispredict=0 throughout.
- Cold tables, PC=10'h005 always taken, 12 request/resolve pairs:
  - Predictions 1-11 = 0 with mispredict=1.
  - Prediction 12 = 1 with mispredict=0 (local ctr[3FF]=3'b100 selected, choice=01).
- pred_valid held high in WAIT and resolve_valid pulsed in IDLE -> no second pred_out_valid and no table change; the next prediction equals the cold-table value 0.
- Reset pulsed low during WAIT after 5 taken resolves for PC=10'h005 -> INIT reruns for 4096 cycles; the next prediction for 10'h005 is 0 and the GHR reads 0.
- With BP_STATS_EN, after the 12-branch scenario -> pred_count=12, mispred_count=11. Without it, both are 0.
- Alternating T/N on PC=10'h3FF for 40 branches -> local history converges; the last 8 predictions are all correct (mispredict=0).
